// File: rtl/vpu_wb_coalesce.sv
// Write-back coalescer: merges byte-enabled element beats into whole-register VRF writes.
// Optional combinational forwarding lookup is compiled in with VPU_WBC_FWD_EN.
module vpu_wb_coalesce #(
    parameter int VLEN = 64
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [4:0]        in_addr_i,
    input  logic [VLEN/8-1:0] in_bweb_i,
    input  logic [VLEN-1:0]   in_data_i,
    input  logic              flush_i,
    output logic              flush_done_o,
    output logic              busy_o,
    output logic              vrf_valid_o,
    input  logic              vrf_ready_i,
    output logic [4:0]        vrf_addr_o,
    output logic [VLEN/8-1:0] vrf_bweb_o,
    output logic [VLEN-1:0]   vrf_data_o,
    input  logic [4:0]        fwd_addr_i,
    output logic              fwd_hit_o,
    output logic [VLEN/8-1:0] fwd_bweb_o,
    output logic [VLEN-1:0]   fwd_data_o,
    output logic [1:0]        state_o
);
    localparam int NB = VLEN / 8;

    typedef enum logic [1:0] {IDLE = 2'd0, MERGE = 2'd1, FLUSH = 2'd2} state_t;
    state_t state_q, state_d;

    logic            ent_v, out_v;
    logic [4:0]      ent_addr, out_addr;
    logic [NB-1:0]   ent_bweb, out_bweb;
    logic [VLEN-1:0] ent_data, out_data;

    logic            accept, beat_nz, same, evict_old, move_ent, ent_v_next;
    logic            m_v;
    logic [4:0]      m_addr;
    logic [NB-1:0]   m_bweb;
    logic [VLEN-1:0] m_data;

    // Handshake: a beat transfers on in_valid_i && in_ready_o; a VRF write on vrf_valid_o && vrf_ready_i.
    assign in_ready_o  = !out_v || vrf_ready_i;
    assign accept      = in_valid_i && in_ready_o;
    assign beat_nz     = accept && (|in_bweb_i);
    assign same        = ent_v && (ent_addr == in_addr_i);
    assign vrf_valid_o = out_v;
    assign vrf_addr_o  = out_addr;
    assign vrf_bweb_o  = out_bweb;
    assign vrf_data_o  = out_data;
    assign busy_o      = ent_v || out_v || (state_q == FLUSH);
    assign state_o     = state_q;

    // A fresh entry starts from zero so unenabled bytes never carry stale data.
    always_comb begin
        evict_old = beat_nz && ent_v && !same;
        m_v       = ent_v;
        m_addr    = ent_addr;
        m_bweb    = ent_bweb;
        m_data    = ent_data;
        if (beat_nz) begin
            m_v    = 1'b1;
            m_addr = in_addr_i;
            if (!same) begin
                m_bweb = '0;
                m_data = '0;
            end
            m_bweb = m_bweb | in_bweb_i;
            for (int b = 0; b < NB; b++) begin
                if (in_bweb_i[b]) m_data[8*b +: 8] = in_data_i[8*b +: 8];
            end
        end
    end

    // Evicting the old entry takes the output slot, so a new full entry waits a cycle.
    assign move_ent     = !evict_old && in_ready_o && m_v && ((&m_bweb) || (state_q == FLUSH));
    assign ent_v_next   = m_v && !move_ent;
    assign flush_done_o = (state_q == FLUSH) && !ent_v && !out_v && !beat_nz;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, MERGE: begin
                if (flush_i)         state_d = FLUSH;
                else if (ent_v_next) state_d = MERGE;
                else                 state_d = IDLE;
            end
            FLUSH:   if (flush_done_o) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            ent_v    <= 1'b0;
            ent_addr <= '0;
            ent_bweb <= '0;
            ent_data <= '0;
            out_v    <= 1'b0;
            out_addr <= '0;
            out_bweb <= '0;
            out_data <= '0;
        end else begin
            state_q  <= state_d;
            ent_v    <= ent_v_next;
            ent_addr <= m_addr;
            ent_bweb <= m_bweb;
            ent_data <= m_data;
            if (evict_old) begin
                out_v    <= 1'b1;
                out_addr <= ent_addr;
                out_bweb <= ent_bweb;
                out_data <= ent_data;
            end else if (move_ent) begin
                out_v    <= 1'b1;
                out_addr <= m_addr;
                out_bweb <= m_bweb;
                out_data <= m_data;
            end else if (vrf_ready_i) begin
                out_v <= 1'b0;
            end
        end
    end

`ifdef VPU_WBC_FWD_EN
    logic e_hit, o_hit;
    assign e_hit = ent_v && (ent_addr == fwd_addr_i);
    assign o_hit = out_v && (out_addr == fwd_addr_i);

    // The entry is younger than the output register, so its bytes win.
    always_comb begin
        fwd_hit_o  = e_hit || o_hit;
        fwd_bweb_o = (e_hit ? ent_bweb : '0) | (o_hit ? out_bweb : '0);
        fwd_data_o = '0;
        for (int b = 0; b < NB; b++) begin
            if (e_hit && ent_bweb[b])      fwd_data_o[8*b +: 8] = ent_data[8*b +: 8];
            else if (o_hit && out_bweb[b]) fwd_data_o[8*b +: 8] = out_data[8*b +: 8];
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^fwd_addr_i;
    assign fwd_hit_o  = 1'b0;
    assign fwd_bweb_o = '0;
    assign fwd_data_o = '0;
`endif

endmodule

// File: doc/vpu_wb_coalesce.md
VPU_WB_COALESCE -- requirements
Module: VPU_wb_coalesce

Interface
REQ-001 SHALL have parameter VLEN, default 64: vector register width in bits; VLEN/8 byte-enables.
REQ-002 SHALL have ports `clk_i` (in, 1, clock) and `rst_ni` (in, 1, reset). There is one clock; reset is asynchronous and active-low.
REQ-003 SHALL have ports `in_valid_i` (in, 1) and `in_ready_o` (out, 1): element-write beat from a VPU execution unit, using a valid/ready handshake.
REQ-004 SHALL have ports `in_addr_i` (in, 5), `in_bweb_i` (in, VLEN/8) and `in_data_i` (in, VLEN): destination vreg, byte-enable (1 = write) and byte-lane-aligned data.
REQ-005 SHALL have port `flush_i` (in, 1): single-cycle pulse at end of instruction.
REQ-006 SHALL have port `flush_done_o` (out, 1): single-cycle pulse once all buffered data has been handed to the VRF.
REQ-007 SHALL have port `busy_o` (out, 1): entry, output register or flush pending is non-empty.
REQ-008 SHALL have ports `vrf_valid_o` (out, 1), `vrf_ready_i` (in, 1), `vrf_addr_o` (out, 5), `vrf_bweb_o` (out, VLEN/8) and `vrf_data_o` (out, VLEN): VRF write port.
REQ-009 SHALL have ports `fwd_addr_i` (in, 5), `fwd_hit_o` (out, 1), `fwd_bweb_o` (out, VLEN/8) and `fwd_data_o` (out, VLEN): forwarding lookup.

Function
REQ-010 SHALL hold one coalescing entry (valid, addr, bweb, data) and one output register (valid, addr, bweb, data).
REQ-011 SHALL drive `in_ready_o` = !out_valid || `vrf_ready_i`.
- A beat transfers when `in_valid_i` && `in_ready_o`.
REQ-012 SHALL handle a beat with all-zero bweb as follows:
- accept it;
- leave the entry unchanged;
- still apply REQ-015 and REQ-016.
REQ-013 SHALL merge a beat whose addr equals the valid entry addr:
- every byte with `in_bweb_i`=1 is overwritten by the new data;
- entry bweb |= `in_bweb_i`.
REQ-014 SHALL, for a beat with a different addr (or an empty entry):
- move the old entry (if valid) to the output register;
- load the beat into the entry.
REQ-015 SHALL, when the post-merge entry bweb is all ones:
- move the entry to the output register on the same edge;
- clear the entry.
- Latency: beat at edge N, `vrf_valid_o` high after edge N.
REQ-016 SHALL NOT move two entries into the output register on the same edge. If REQ-014 and REQ-015 both apply:
- the old entry goes out first;
- the new full entry stays in the entry and is evicted at the next free slot.
REQ-017 SHALL drive `vrf_valid_o` = out_valid. The output register clears on `vrf_valid_o` && `vrf_ready_i` unless it is reloaded on the same edge.
REQ-018 SHALL hold `vrf_addr_o`, `vrf_bweb_o` and `vrf_data_o` stable while `vrf_valid_o` && !`vrf_ready_i`.
REQ-019 SHALL implement FSM states IDLE, MERGE and FLUSH:
- IDLE->MERGE on the first accepted non-zero beat;
- MERGE->IDLE when the entry clears;
- any->FLUSH on `flush_i`;
- FLUSH->IDLE when entry and output are empty, which also pulses `flush_done_o` for 1 cycle.
REQ-020 SHALL, in FLUSH, move the entry to the output register whenever the output is free or draining.
REQ-021 SHALL treat `flush_i` coincident with an accepted beat as follows: the beat is merged first and then flushed.
REQ-022 SHALL treat `flush_i` with both entry and output empty as follows: pulse `flush_done_o` on the next cycle.
REQ-023 SHALL ignore `flush_i` while already in FLUSH. Beats accepted during FLUSH are included in the same flush.
REQ-024 SHALL never reorder writes to the same addr: an output-register write is always older than the entry.

Reset
REQ-025 SHALL, on `rst_ni`=0 asynchronously:
- clear the entry and output register, and set the FSM to IDLE;
- drive `vrf_valid_o`=0, `flush_done_o`=0, `busy_o`=0 and `fwd_hit_o`=0;
- drive all data/addr/bweb outputs to 0;
- discard any in-flight merge or flush.
- `in_ready_o`=1.
REQ-026 SHALL begin accepting beats on the first rising edge after `rst_ni` is deasserted.

Configuration
REQ-027 SHALL compile forwarding in with macro VPU_WBC_FWD_EN:
- `fwd_hit_o`=1 if the entry or the output register addr equals `fwd_addr_i`;
- `fwd_bweb_o` is the OR of the matching bweb;
- `fwd_data_o` takes each byte from the entry if the entry enables it, else from the output register;
- the lookup is combinational.
REQ-028 SHALL, without VPU_WBC_FWD_EN, keep the ports and drive `fwd_hit_o`, `fwd_bweb_o` and `fwd_data_o` to constant 0.

Verification
REQ-029 SHALL cover full-register coalescing (VLEN=64, `vrf_ready_i`=1):
- stimulus: 8 beats, addr 3, bweb 0x01,0x02,...,0x80, data byte i=i;
- response: exactly one VRF write, addr 3, bweb 0xFF, data 0x0706050403020100, one cycle after beat 8.
REQ-030 SHALL cover an address switch:
- stimulus: beats addr 4 bweb 0x0F, then addr 5 bweb 0x03;
- response: VRF write addr 4 bweb 0x0F; entry holds addr 5 until `flush_i`, then VRF write addr 5 bweb 0x03, then `flush_done_o` pulse.
REQ-031 SHALL cover backpressure:
- stimulus: `vrf_ready_i`=0 with output occupied;
- response: `in_ready_o`=0 and output fields stable; raising `vrf_ready_i` completes the write and restores `in_ready_o`=1 in the same cycle.
REQ-032 SHALL cover overlap and simultaneous flush:
- stimulus: overlapping beats addr 2 bweb 0x0F data 0xAA.., then bweb 0x03 data 0x55.. together with `flush_i`;
- response: write bweb 0x0F, bytes 0-1=0x55, bytes 2-3=0xAA.
REQ-033 SHALL cover reset mid-flush:
- stimulus: `rst_ni` low while in FLUSH with output pending;
- response: `vrf_valid_o`=0 immediately, no `flush_done_o`, `busy_o`=0.
REQ-034 SHALL cover forwarding (with VPU_WBC_FWD_EN):
- stimulus: entry addr 7 bweb 0x0F, lookup `fwd_addr_i`=7;
- response: `fwd_hit_o`=1, `fwd_bweb_o`=0x0F; without the macro, `fwd_hit_o`=0.
